// File: rtl/add_seq_pkg.sv
// Shared constants and state encoding for the chunk-serial adder.
package add_seq_pkg;

    localparam int unsigned CHUNK_W    = 16;
    localparam int unsigned NCHUNK_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/CLA_16bit.sv
// 16-bit two-level carry-lookahead adder (4 groups of 4 bits).
module CLA_16bit (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] s,
    output logic        cout,
    output logic        p,
    output logic        g
);

    // Carries into bits 0..3 of a 4-bit group, flattened lookahead terms.
    function automatic logic [3:0] carries4(input logic [3:0] pv, input logic [3:0] gv,
                                            input logic c0);
        logic [3:0] c;
        c[0] = c0;
        c[1] = gv[0] | (pv[0] & c0);
        c[2] = gv[1] | (pv[1] & gv[0]) | (pv[1] & pv[0] & c0);
        c[3] = gv[2] | (pv[2] & gv[1]) | (pv[2] & pv[1] & gv[0]) | (pv[2] & pv[1] & pv[0] & c0);
        return c;
    endfunction

    function automatic logic group_g(input logic [3:0] pv, input logic [3:0] gv);
        return gv[3] | (pv[3] & gv[2]) | (&pv[3:2] & gv[1]) | (&pv[3:1] & gv[0]);
    endfunction

    logic [15:0] pb;
    logic [15:0] gb;
    logic [3:0]  pp;
    logic [3:0]  gg;
    logic [3:0]  cg;
    logic [15:0] c;

    always_comb begin
        pb = a ^ b;
        gb = a & b;
        for (int unsigned k = 0; k < 4; k++) begin
            pp[k] = &pb[4*k +: 4];
            gg[k] = group_g(pb[4*k +: 4], gb[4*k +: 4]);
        end
        cg = carries4(pp, gg, cin);
        for (int unsigned k = 0; k < 4; k++) begin
            c[4*k +: 4] = carries4(pb[4*k +: 4], gb[4*k +: 4], cg[k]);
        end
        s    = pb ^ c;
        p    = &pp;
        g    = group_g(pp, gg);
        cout = g | (p & cin);
    end

endmodule

// File: rtl/add_seq_64.sv
// Multi-cycle W-bit adder/subtractor: one 16-bit chunk per cycle through a shared CLA.
module add_seq_64
    import add_seq_pkg::*;
#(
    parameter int unsigned NCHUNK = NCHUNK_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    sub,
    input  logic [CHUNK_W*NCHUNK-1:0] a,
    input  logic [CHUNK_W*NCHUNK-1:0] b,
    input  logic                    cin,
    output logic                    busy,
    output logic                    done,
    output logic [CHUNK_W*NCHUNK-1:0] s,
    output logic                    cout,
    output logic                    ovf
);

    localparam int unsigned W     = CHUNK_W * NCHUNK;
    localparam int unsigned IDX_W = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NCHUNK - 1);

    state_t             state;
    logic [IDX_W-1:0]   idx;
    logic               carry;
    logic [W-1:0]       a_r;
    logic [W-1:0]       b_r;
    logic [CHUNK_W-1:0] a_chunk;
    logic [CHUNK_W-1:0] b_chunk;
    logic [CHUNK_W-1:0] cla_s;
    logic               cla_cout;

    assign a_chunk = a_r[idx*CHUNK_W +: CHUNK_W];
    assign b_chunk = b_r[idx*CHUNK_W +: CHUNK_W];

    CLA_16bit u_cla (
        .a    (a_chunk),
        .b    (b_chunk),
        .cin  (carry),
        .s    (cla_s),
        .cout (cla_cout),
        .p    (),
        .g    ()
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            idx   <= '0;
            carry <= 1'b0;
            a_r   <= '0;
            b_r   <= '0;
            s     <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        a_r   <= a;
                        b_r   <= sub ? ~b : b;
                        carry <= sub | cin;
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    s[idx*CHUNK_W +: CHUNK_W] <= cla_s;
                    carry <= cla_cout;
                    if (idx == LAST) begin
                        // carry into the MSB is recovered from the sum bit
                        cout  <= cla_cout;
                        ovf   <= a_chunk[CHUNK_W-1] ^ b_chunk[CHUNK_W-1] ^ cla_s[CHUNK_W-1] ^ cla_cout;
                        idx   <= '0;
                        state <= ST_DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
